hamming_decoder: RTL and testbench
==================================

HAMMING_DECODER -- requirements
Module: hamming_decoder

Interface
REQ-001 Parameter CNT_W, default 8: width of the corrected-error counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 enable  input  1  decoder enable; low blocks acceptance of new codewords.
REQ-005 in_valid  input  1  codeword on code_in is valid.
REQ-006 in_ready  output  1  decoder accepts code_in this cycle.
REQ-007 code_in  input  7  Hamming(7,4) codeword; layout bit0=p1, bit1=p2, bit2=d0, bit3=p3, bit4=d1, bit5=d2, bit6=d3.
REQ-008 out_valid  output  1  data_out, syndrome and err_corrected are valid.
REQ-009 out_ready  input  1  downstream accepts the output word.
REQ-010 data_out  output  4  corrected data {d3,d2,d1,d0}.
REQ-011 syndrome  output  3  {s3,s2,s1} of the output word.
REQ-012 err_corrected  output  1  the output word had a nonzero syndrome and one bit was corrected.
REQ-013 cnt_clr  input  1  synchronous clear of err_count.
REQ-014 err_count  output  CNT_W  saturating count of corrected words.

Function
REQ-015 Syndrome bits SHALL be: s1=c0^c2^c4^c6, s2=c1^c2^c5^c6, s3=c3^c4^c5^c6.
REQ-016 A nonzero syndrome S SHALL invert codeword bit S-1 before data extraction; S=0 SHALL pass the codeword unchanged.
REQ-017 Double-bit errors are out of scope: the block SHALL apply the REQ-016 correction regardless, with no separate detection flag.
REQ-018 The pipeline SHALL have two register stages: stage 1 holds codeword and syndrome; stage 2 holds data_out, syndrome and err_corrected.
REQ-019 Stage 2 SHALL load when (~out_valid | out_ready); this is s2_load.
REQ-020 in_ready SHALL equal enable & (~s1_valid | s2_load).
REQ-021 An input transfer (in_valid & in_ready) SHALL set s1_valid; stage 1 moving to stage 2 without a new input SHALL clear it.
REQ-022 Without backpressure, latency SHALL be 2 cycles from input transfer to out_valid, at a throughput of one word per cycle.
REQ-023 While out_valid=1 and out_ready=0, the stage-2 outputs SHALL hold stable and no accepted word SHALL be dropped or duplicated.
REQ-024 When enable is low, in-flight words SHALL still drain to the output.
REQ-025 err_count SHALL increment by 1 on each output transfer (out_valid & out_ready) with err_corrected=1.
REQ-026 err_count SHALL saturate at 2^CNT_W-1.
REQ-027 cnt_clr SHALL set err_count to 0 next cycle; clear wins over a simultaneous increment.

Reset
REQ-028 When rst_n=0 at a clock edge, the block SHALL clear s1_valid, out_valid, data_out, syndrome, err_corrected and err_count to 0.
REQ-029 While rst_n=0, in_ready SHALL be 0.
REQ-030 Words in flight at reset SHALL be discarded.
REQ-031 The first input transfer SHALL be possible in the first cycle with rst_n=1 and enable=1.

Configuration
REQ-032 With macro HAMMING_DEC_STATS_EN defined, the err_count logic and cnt_clr behaviour SHALL be compiled in per REQ-025..REQ-027.
REQ-033 Without HAMMING_DEC_STATS_EN, err_count SHALL be constant 0, cnt_clr SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-034 Clean word: code_in=7'h55, out_ready=1 -> 2 cycles later data_out=4'b1011, syndrome=0, err_corrected=0.
REQ-035 Data-bit error: code_in=7'h45 (bit4 flipped) -> data_out=4'b1011, syndrome=3'b101, err_corrected=1, err_count increments by 1.
REQ-036 Parity-bit error: code_in=7'h54 (bit0 flipped) -> data_out=4'b1011, syndrome=3'b001, err_corrected=1.
REQ-037 Exhaustive check: all 16 data values x 8 error positions (none or bit0..6), encoded per REQ-007 -> data_out always equals the original data.
REQ-038 Backpressure: stream 5 words with out_ready toggled randomly -> outputs stable while stalled, order preserved, in_ready=0 once both stages are full and out_ready=0.
REQ-039 Counter boundaries: CNT_W=2 with 5 corrected transfers -> err_count=3; cnt_clr asserted in the same cycle as a corrected transfer -> err_count=0; rst_n low mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/hamming_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// hamming_decoder
//
// Purpose:
//   Two-stage pipelined Hamming(7,4) single-error-correcting decoder with a
//   valid/ready handshake on both sides and an optional saturating counter of
//   corrected words.
//
//   Stage 1 registers the raw codeword together with its syndrome.
//   Stage 2 registers the corrected data, the syndrome and a corrected flag.
//   Double-bit errors are not detected: any nonzero syndrome is treated as a
//   single-bit error and the indicated bit is flipped.
//
// Codeword layout (code_in):
//   bit0=p1 bit1=p2 bit2=d0 bit3=p3 bit4=d1 bit5=d2 bit6=d3
//
// Ports:
//   clk           in   single clock, rising edge
//   rst_n         in   synchronous active-low reset
//   enable        in   low blocks acceptance of new codewords (pipeline drains)
//   in_valid      in   code_in carries a codeword
//   in_ready      out  codeword accepted this cycle
//   code_in       in   7-bit codeword
//   out_valid     out  data_out / syndrome / err_corrected are valid
//   out_ready     in   downstream takes the output word this cycle
//   data_out      out  corrected data {d3,d2,d1,d0}
//   syndrome      out  {s3,s2,s1} of the output word
//   err_corrected out  output word had a nonzero syndrome (one bit flipped)
//   cnt_clr       in   synchronous clear of err_count
//   err_count     out  saturating count of corrected words transferred out
//
// Parameter:
//   CNT_W         width of err_count (default 8)
//
// Configuration macro:
//   HAMMING_DEC_STATS_EN  when defined, err_count / cnt_clr are live; when
//                         undefined, err_count is tied to zero and cnt_clr is
//                         ignored (the port list does not change).
// -----------------------------------------------------------------------------
module hamming_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic [2:0]       syndrome,
  output logic             err_corrected,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_count
);

  // ---------------------------------------------------------------------------
  // Input-side syndrome. Each syndrome bit is the parity of the codeword bits
  // whose (1-based) position has that bit set, so a single flipped bit at
  // index i yields syndrome i+1.
  // ---------------------------------------------------------------------------
  logic [2:0] syn_in;

  assign syn_in[0] = code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6];
  assign syn_in[1] = code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6];
  assign syn_in[2] = code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6];

  // ---------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------
  logic       s1_valid;
  logic [6:0] s1_code_reg;
  logic [2:0] s1_syn_reg;
  logic       s2_load;
  logic       in_xfer;

  // Stage 2 can take a new word when it is empty or its word leaves now.
  assign s2_load = ~out_valid | out_ready;

  // Stage 1 can take a new word when it is empty or its word moves on now.
  // Gating with rst_n keeps the input closed for the whole reset period.
  assign in_ready = rst_n & enable & (~s1_valid | s2_load);
  assign in_xfer  = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: raw codeword + syndrome
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_code_reg <= '0;
      s1_syn_reg  <= '0;
    end else if (in_xfer) begin
      s1_valid    <= 1'b1;
      s1_code_reg <= code_in;
      s1_syn_reg  <= syn_in;
    end else if (s2_load) begin
      // Word moved to stage 2 and nothing replaced it.
      s1_valid    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Correction: flip the bit addressed by the syndrome. A zero syndrome
  // matches no position, so the word passes through unchanged.
  // ---------------------------------------------------------------------------
  logic [6:0] corrected;

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_correct
      assign corrected[gi] = s1_code_reg[gi] ^ (s1_syn_reg == 3'(gi + 1));
    end
  endgenerate

  logic [3:0] s1_data;

  assign s1_data = {corrected[6], corrected[5], corrected[4], corrected[2]};

  // ---------------------------------------------------------------------------
  // Stage 2: corrected data, syndrome and flag. Holds while stalled so the
  // downstream side sees a stable word until it accepts it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      data_out      <= '0;
      syndrome      <= '0;
      err_corrected <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out      <= s1_data;
        syndrome      <= s1_syn_reg;
        err_corrected <= |s1_syn_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Corrected-word statistics
  // ---------------------------------------------------------------------------
`ifdef HAMMING_DEC_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             out_xfer;
  logic [CNT_W-1:0] err_count_reg;

  assign out_xfer = out_valid & out_ready;

  // Clear has priority over a same-cycle increment; the count sticks at
  // all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_reg <= '0;
    end else if (cnt_clr) begin
      err_count_reg <= '0;
    end else if (out_xfer && err_corrected && (err_count_reg != CNT_MAX)) begin
      err_count_reg <= err_count_reg + CNT_W'(1);
    end
  end

  assign err_count = err_count_reg;
`else
  // Statistics compiled out: the clear input is accepted but has no effect.
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_hamming_decoder
//
// Directed bench for hamming_decoder (CNT_W=2). Inputs are driven just after
// the rising edge; handshakes are observed on the falling edge. Expected
// words come from an independent encoder plus the injected error position.
// err_count expectations depend on HAMMING_DEC_STATS_EN.
// -----------------------------------------------------------------------------
module tb_hamming_decoder;

  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAMMING_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       code_in;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       data_out;
  logic [2:0]       syndrome;
  logic             err_corrected;
  logic             cnt_clr;
  logic [CNT_W-1:0] err_count;

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .code_in       (code_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_out      (data_out),
    .syndrome      (syndrome),
    .err_corrected (err_corrected),
    .cnt_clr       (cnt_clr),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];     // {data[3:0], syndrome[2:0], err_corrected}
  logic [7:0] next_exp;
  int         model_cnt = 0;
  bit         stall_prev = 1'b0;
  logic [3:0] held_data;
  logic [2:0] held_syn;
  logic       held_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

  // pos = 0: clean word; pos = 1..7: flip codeword bit pos-1 (syndrome = pos)
  task automatic drive_word(input logic [3:0] d, input int pos);
    logic [6:0] c;
    c = encode(d);
    if (pos != 0) c[pos-1] = ~c[pos-1];
    code_in  = c;
    in_valid = 1'b1;
    next_exp = {d, 3'(pos), (pos != 0)};
  endtask

  task automatic drive_raw(input logic [6:0] c, input logic [7:0] e);
    code_in  = c;
    in_valid = 1'b1;
    next_exp = e;
  endtask

  // One clock cycle: observe handshakes at the falling edge, then advance to
  // just after the rising edge and check the counter.
  task automatic tick(output bit acc);
    logic [7:0] e;
    @(negedge clk);
    acc = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      model_cnt  = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'(1));
        chk("stall_data", 32'(data_out), 32'(held_data));
        chk("stall_syn", 32'(syndrome), 32'(held_syn));
        chk("stall_err", 32'(err_corrected), 32'(held_err));
      end
      e = 8'h00;
      if (out_valid && out_ready) begin
        chk("out_expected", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("data_out", 32'(data_out), 32'(e[7:4]));
          chk("syndrome", 32'(syndrome), 32'(e[3:1]));
          chk("err_corrected", 32'(err_corrected), 32'(e[0]));
        end
      end
      if (cnt_clr) model_cnt = 0;
      else if (e[0] && model_cnt < CNT_MAX) model_cnt++;
      stall_prev = out_valid && !out_ready;
      held_data  = data_out;
      held_syn   = syndrome;
      held_err   = err_corrected;
      if (in_valid && in_ready) begin
        exp_q.push_back(next_exp);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("err_count", 32'(err_count), STATS ? 32'(model_cnt) : 32'(0));
  endtask

  task automatic drain();
    bit a;
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 30) begin
      tick(a);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    bit acc;
    int budget;

    rst_n     = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    code_in   = '0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    next_exp  = '0;

    // Reset state
    tick(acc);
    tick(acc);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_data", 32'(data_out), 32'(0));
    chk("rst_syn", 32'(syndrome), 32'(0));
    chk("rst_err", 32'(err_corrected), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));

    // Clean word, accepted in the first cycle out of reset; 2-cycle latency
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive_raw(7'h55, {4'b1011, 3'b000, 1'b0});
    #1;
    chk("first_in_ready", 32'(in_ready), 32'(1));
    tick(acc);
    chk("clean_accept", 32'(acc), 32'(1));
    chk("lat1_out_valid", 32'(out_valid), 32'(0));
    in_valid = 1'b0;
    tick(acc);
    chk("lat2_out_valid", 32'(out_valid), 32'(1));
    chk("clean_data", 32'(data_out), 32'(4'b1011));
    chk("clean_syn", 32'(syndrome), 32'(0));
    chk("clean_err", 32'(err_corrected), 32'(0));
    drain();

    // Data-bit and parity-bit errors back to back
    drive_raw(7'h45, {4'b1011, 3'b101, 1'b1});
    tick(acc);
    chk("d_err_accept", 32'(acc), 32'(1));
    drive_raw(7'h54, {4'b1011, 3'b001, 1'b1});
    tick(acc);
    chk("p_err_accept", 32'(acc), 32'(1));
    drain();
    chk("cnt_after_two", 32'(err_count), STATS ? 32'(2) : 32'(0));

    // Exhaustive: 16 data values x 8 error positions, full throughput
    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 8; p++) begin
        drive_word(4'(d), p);
        tick(acc);
        chk("stream_accept", 32'(acc), 32'(1));
      end
    end
    drain();
    chk("cnt_saturated", 32'(err_count), STATS ? 32'(CNT_MAX) : 32'(0));

    // Backpressure: fill both stages, input must close
    out_ready = 1'b0;
    drive_word(4'h3, 0);
    tick(acc);
    chk("bp_accept_a", 32'(acc), 32'(1));
    drive_word(4'hC, 2);
    tick(acc);
    chk("bp_accept_b", 32'(acc), 32'(1));
    drive_word(4'h9, 6);
    #1;
    chk("bp_full_in_ready", 32'(in_ready), 32'(0));
    // Three more words with random out_ready; stability checked in tick
    for (int i = 0; i < 3; i++) begin
      drive_word(4'(4'h9 + i), (i * 3) % 8);
      budget = 40;
      acc = 1'b0;
      while (!acc && budget > 0) begin
        out_ready = 1'($urandom_range(0, 1));
        tick(acc);
        budget--;
      end
      chk("bp_accept_timeout", 32'(acc), 32'(1));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick(acc);
    end
    drain();

    // enable low: no new acceptance, in-flight words drain
    drive_word(4'h5, 3);
    tick(acc);
    drive_word(4'hA, 0);
    tick(acc);
    enable = 1'b0;
    drive_word(4'hF, 7);
    #1;
    chk("dis_in_ready", 32'(in_ready), 32'(0));
    for (int i = 0; i < 4; i++) tick(acc);
    chk("dis_drained", 32'(exp_q.size()), 32'(0));
    chk("dis_out_valid", 32'(out_valid), 32'(0));
    in_valid = 1'b0;
    enable   = 1'b1;

    // Clear coinciding with a corrected transfer
    out_ready = 1'b0;
    drive_word(4'h6, 5);
    tick(acc);
    in_valid = 1'b0;
    tick(acc);
    chk("clr_stalled_valid", 32'(out_valid), 32'(1));
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    tick(acc);
    cnt_clr   = 1'b0;
    chk("clr_wins", 32'(err_count), 32'(0));
    drain();

    // Five corrected transfers saturate a 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      drive_word(4'(i), i + 1);
      tick(acc);
    end
    drain();
    chk("cnt_five", 32'(err_count), STATS ? 32'(3) : 32'(0));

    // Reset mid-stream: in-flight words discarded
    drive_word(4'h1, 0);
    tick(acc);
    drive_word(4'h2, 4);
    tick(acc);
    rst_n = 1'b0;
    drive_word(4'h3, 0);
    tick(acc);
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(0));
    chk("midrst_cnt", 32'(err_count), 32'(0));
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick(acc);
    chk("postrst_out_valid", 32'(out_valid), 32'(0));
    drive_raw(7'h55, {4'b1011, 3'b000, 1'b0});
    tick(acc);
    chk("postrst_accept", 32'(acc), 32'(1));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
